// File: rtl/imem_arbiter_if.sv
// Request/response and BRAM-side signal bundle for the instruction-memory arbiter.
// slave = arbiter view; master = requesters plus memory (the bench side).
interface imem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_lock;
  logic              err_clr;
  logic              err_misalign;
  logic              err_range;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata,
           dbg_lock, err_clr, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, dbg_gnt, dbg_rvalid,
           dbg_rdata, err_misalign, err_range, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata,
           dbg_lock, err_clr, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, dbg_gnt, dbg_rvalid,
           dbg_rdata, err_misalign, err_range, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch/debug arbiter for a single-port instruction BRAM: zero-cycle grant, read data 1 cycle later.
// Requesters hold req until gnt; fetch has priority, debug forced in after STARVE_MAX denials or via lock.
module imem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_arbiter_if.slave bus
);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        fetch_gnt, dbg_gnt, any_gnt;
  logic [31:0] sel_addr;
  logic        sel_oor, sel_mis;
  logic        rsp_fetch, rsp_dbg, rsp_oor;
  logic [31:0] rsp_data, fetch_hold, dbg_hold;
  logic        err_mis_q, err_rng_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = bus.dbg_lock ? LOCKED : NORMAL;
    fetch_gnt  = 1'b0;
    dbg_gnt    = 1'b0;
    if (state == LOCKED) begin
      dbg_gnt = bus.dbg_req;
    end else if (bus.dbg_req && (starve_cnt == STARVE_LIM)) begin
      dbg_gnt = 1'b1;
    end else begin
      fetch_gnt = bus.fetch_req;
      dbg_gnt   = bus.dbg_req & ~bus.fetch_req;
    end
    starve_nxt = starve_cnt;
    if (!bus.dbg_req || dbg_gnt) begin
      starve_nxt = '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // Idle cycles present the fetch address to the BRAM; mem_en stays low so it is harmless.
  assign any_gnt  = fetch_gnt | dbg_gnt;
  assign sel_addr = dbg_gnt ? bus.dbg_addr : bus.fetch_addr;
  assign sel_oor  = |sel_addr[31:ADDR_W+2];
  assign sel_mis  = |sel_addr[1:0];

  assign bus.fetch_gnt = fetch_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_en    = any_gnt & ~sel_oor;
  assign bus.mem_we    = dbg_gnt & bus.dbg_we;
  assign bus.mem_addr  = sel_addr[ADDR_W+1:2];
  assign bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_fetch  <= 1'b0;
      rsp_dbg    <= 1'b0;
      rsp_oor    <= 1'b0;
      fetch_hold <= '0;
      dbg_hold   <= '0;
      err_mis_q  <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      rsp_fetch <= fetch_gnt;
      rsp_dbg   <= dbg_gnt & ~bus.dbg_we;
      rsp_oor   <= any_gnt & sel_oor;
      if (rsp_fetch) fetch_hold <= rsp_data;
      if (rsp_dbg)   dbg_hold   <= rsp_data;
      // A new error outranks a simultaneous clear.
      if (any_gnt && sel_mis)  err_mis_q <= 1'b1;
      else if (bus.err_clr)    err_mis_q <= 1'b0;
      if (any_gnt && sel_oor)  err_rng_q <= 1'b1;
      else if (bus.err_clr)    err_rng_q <= 1'b0;
    end
  end

  assign rsp_data         = rsp_oor ? NOP_INSN : bus.mem_rdata;
  assign bus.fetch_rvalid = rsp_fetch;
  assign bus.fetch_rdata  = rsp_fetch ? rsp_data : fetch_hold;
  assign bus.dbg_rvalid   = rsp_dbg;
  assign bus.dbg_rdata    = rsp_dbg ? rsp_data : dbg_hold;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_range    = err_rng_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_imem_arbiter;
  localparam int          AW   = 12;
  localparam int          SMAX = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW)) bus();
  imem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] bram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        bram_ready = 1'b0;
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Synchronous-read BRAM; contents loaded on the first clock edge.
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < (1<<AW); i++) bram[i] <= init_word(i);
      bram_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= bram[bus.mem_addr];
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({bus.fetch_gnt, bus.fetch_rvalid, bus.fetch_rdata, bus.dbg_gnt, bus.dbg_rvalid,
                 bus.dbg_rdata, bus.err_misalign, bus.err_range, bus.mem_en, bus.mem_we,
                 bus.mem_addr, bus.mem_wdata});
  endfunction

  function automatic logic [31:0] rand_addr();
    int s;
    logic [31:0] a;
    s = $urandom_range(0, 19);
    a = 32'($urandom_range(0, 31)) << 2;
    if (s < 3)      a = a | 32'($urandom_range(1, 3));
    else if (s < 6) a = a | 32'h0001_0000 | ($urandom & 32'hFFFF_0000);
    return a;
  endfunction

  task automatic idle();
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_lock = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_outs got=%h exp=0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL post_reset_outs got=%h exp=0", all_outs());
    end
  endtask

  task automatic test_fetch_seq();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin bus.fetch_req = 1'b1; bus.fetch_addr = 32'(k * 4); end
      else idle();
      #1;
      if (k < 3) begin
        checks++;
        if ({bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 12'(k)) begin
          failures++; $display("FAIL fseq_gnt k=%0d got=%b addr=%0d exp=1010 addr=%0d", k,
            {bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, k);
        end
      end
      checks++;
      if (bus.fetch_rvalid !== ((k >= 1) && (k <= 3))) begin
        failures++; $display("FAIL fseq_rvalid k=%0d got=%b", k, bus.fetch_rvalid);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (bus.fetch_rdata !== ref_mem[k-1]) begin
          failures++; $display("FAIL fseq_rdata k=%0d got=%h exp=%h", k, bus.fetch_rdata, ref_mem[k-1]);
        end
      end
    end
  endtask

  task automatic test_starve();
    logic exp_dg;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 10) begin
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h24;
      end else idle();
      #1;
      if (c < 10) begin
        exp_dg = (c == 4) || (c == 9);
        checks++;
        if ({bus.fetch_gnt, bus.dbg_gnt} !== {~exp_dg, exp_dg}) begin
          failures++; $display("FAIL starve_gnt c=%0d got=%b%b exp=%b%b", c, bus.fetch_gnt, bus.dbg_gnt, ~exp_dg, exp_dg);
        end
      end
      checks++;
      if (bus.dbg_rvalid !== ((c == 5) || (c == 10))) begin
        failures++; $display("FAIL starve_rvalid c=%0d got=%b", c, bus.dbg_rvalid);
      end
      if (c == 5 || c == 10) begin
        checks++;
        if (bus.dbg_rdata !== ref_mem[9]) begin
          failures++; $display("FAIL starve_rdata got=%h exp=%h", bus.dbg_rdata, ref_mem[9]);
        end
      end
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8; bus.dbg_lock = 1'b1;
    #1; checks++;
    if ({bus.fetch_gnt, bus.dbg_gnt} !== 2'b10) begin
      failures++; $display("FAIL lock_edge_gnt got=%b%b exp=10", bus.fetch_gnt, bus.dbg_gnt);
    end
    @(negedge clk);
    bus.fetch_addr = 32'hC;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h10; bus.dbg_wdata = 32'hDEAD_BEEF;
    #1; checks++;
    if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== ref_mem[2]) begin
      failures++; $display("FAIL lock_inflight got=%b/%h exp=1/%h", bus.fetch_rvalid, bus.fetch_rdata, ref_mem[2]);
    end
    checks++;
    if ({bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we} !== 4'b0111 || bus.mem_addr !== 12'd4
        || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL lock_write got=%b addr=%0d wdata=%h exp=0111 addr=4 wdata=deadbeef",
        {bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.dbg_we = 1'b0;
    #1; checks++;
    if ({bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.dbg_rvalid} !== 5'b01100) begin
      failures++; $display("FAIL lock_read got=%b exp=01100",
        {bus.fetch_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.dbg_rvalid});
    end
    @(negedge clk);
    bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    #1; checks++;
    if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hDEAD_BEEF || bus.fetch_gnt !== 1'b0) begin
      failures++; $display("FAIL lock_raw got=%b/%h fgnt=%b exp=1/deadbeef fgnt=0",
        bus.dbg_rvalid, bus.dbg_rdata, bus.fetch_gnt);
    end
    @(negedge clk);
    #1; checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      failures++; $display("FAIL unlock_gnt got=%b exp=1", bus.fetch_gnt);
    end
    @(negedge clk);
    idle();
    #1; checks++;
    if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== ref_mem[3]) begin
      failures++; $display("FAIL unlock_rdata got=%b/%h exp=1/%h", bus.fetch_rvalid, bus.fetch_rdata, ref_mem[3]);
    end
  endtask

  task automatic test_range();
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0001_0000;
    #1; checks++;
    if ({bus.fetch_gnt, bus.mem_en} !== 2'b10) begin
      failures++; $display("FAIL range_gnt got=%b%b exp=10", bus.fetch_gnt, bus.mem_en);
    end
    @(negedge clk);
    idle();
    #1; checks++;
    if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== NOP || {bus.err_range, bus.err_misalign} !== 2'b10) begin
      failures++; $display("FAIL range_nop got=%b/%h err=%b%b exp=1/00000013 err=10",
        bus.fetch_rvalid, bus.fetch_rdata, bus.err_range, bus.err_misalign);
    end
    @(negedge clk);
    bus.err_clr = 1'b1;
    #1; checks++;
    if (bus.err_range !== 1'b1) begin
      failures++; $display("FAIL range_sticky got=%b exp=1", bus.err_range);
    end
    @(negedge clk);
    idle();
    #1; checks++;
    if (bus.err_range !== 1'b0) begin
      failures++; $display("FAIL range_clr got=%b exp=0", bus.err_range);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h6;
    #1; checks++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 12'd1 || bus.mem_en !== 1'b1) begin
      failures++; $display("FAIL mis_gnt got=%b addr=%0d en=%b exp=1 addr=1 en=1", bus.dbg_gnt, bus.mem_addr, bus.mem_en);
    end
    @(negedge clk);
    bus.dbg_addr = 32'hA; bus.err_clr = 1'b1;
    #1; checks++;
    if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== ref_mem[1] || bus.err_misalign !== 1'b1) begin
      failures++; $display("FAIL mis_word got=%b/%h err=%b exp=1/%h err=1",
        bus.dbg_rvalid, bus.dbg_rdata, bus.err_misalign, ref_mem[1]);
    end
    @(negedge clk);
    idle();
    #1; checks++;
    if (bus.err_misalign !== 1'b1 || bus.dbg_rdata !== ref_mem[2] || bus.err_range !== 1'b0) begin
      failures++; $display("FAIL mis_set_wins got=%b/%h rng=%b exp=1/%h rng=0",
        bus.err_misalign, bus.dbg_rdata, bus.err_range, ref_mem[2]);
    end
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    idle();
    #1; checks++;
    if (bus.err_misalign !== 1'b0) begin
      failures++; $display("FAIL mis_clr got=%b exp=0", bus.err_misalign);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
    #1; checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      failures++; $display("FAIL rmid_gnt got=%b exp=1", bus.fetch_gnt);
    end
    #1;
    rst_n = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1; checks++;
      if (all_outs() !== '0) begin
        failures++; $display("FAIL rmid_outs c=%0d got=%h exp=0", c, all_outs());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (bus.fetch_rvalid !== 1'b0) begin
        failures++; $display("FAIL rmid_rvalid c=%0d got=%b exp=0", c, bus.fetch_rvalid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit locked = 1'b0, f_pend = 1'b0, d_pend = 1'b0;
    bit exp_fv = 1'b0, exp_dv = 1'b0, e_mis = 1'b0, e_rng = 1'b0;
    bit eg_f, eg_d, inr, is_mis;
    int denied = 0;
    logic [31:0] exp_fd = '0, exp_dd = '0, g_addr, rd;
    logic [AW-1:0] idx;
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      checks++;
      if (bus.fetch_rvalid !== exp_fv || (exp_fv && bus.fetch_rdata !== exp_fd)) begin
        failures++; $display("FAIL rnd_fetch_rsp n=%0d got=%b/%h exp=%b/%h", n, bus.fetch_rvalid, bus.fetch_rdata, exp_fv, exp_fd);
      end
      checks++;
      if (bus.dbg_rvalid !== exp_dv || (exp_dv && bus.dbg_rdata !== exp_dd)) begin
        failures++; $display("FAIL rnd_dbg_rsp n=%0d got=%b/%h exp=%b/%h", n, bus.dbg_rvalid, bus.dbg_rdata, exp_dv, exp_dd);
      end
      checks++;
      if ({bus.err_misalign, bus.err_range} !== {e_mis, e_rng}) begin
        failures++; $display("FAIL rnd_err n=%0d got=%b%b exp=%b%b", n, bus.err_misalign, bus.err_range, e_mis, e_rng);
      end
      if (!f_pend) begin
        bus.fetch_req = ($urandom_range(0, 9) < 6); bus.fetch_addr = rand_addr();
      end
      if (!d_pend) begin
        bus.dbg_req = ($urandom_range(0, 9) < 5); bus.dbg_we = ($urandom_range(0, 2) == 0);
        bus.dbg_addr = rand_addr(); bus.dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) bus.dbg_lock = ~bus.dbg_lock;
      bus.err_clr = ($urandom_range(0, 9) == 0);
      eg_f = 1'b0; eg_d = 1'b0;
      if (locked) eg_d = bus.dbg_req;
      else if (bus.dbg_req && denied >= SMAX) eg_d = 1'b1;
      else begin eg_f = bus.fetch_req; eg_d = bus.dbg_req && !bus.fetch_req; end
      g_addr = eg_d ? bus.dbg_addr : bus.fetch_addr;
      inr    = (g_addr >> (AW + 2)) == 0;
      is_mis = g_addr[1:0] != 2'b00;
      idx    = g_addr[AW+1:2];
      #1;
      checks++;
      if ({bus.fetch_gnt, bus.dbg_gnt} !== {eg_f, eg_d}) begin
        failures++; $display("FAIL rnd_gnt n=%0d got=%b%b exp=%b%b", n, bus.fetch_gnt, bus.dbg_gnt, eg_f, eg_d);
      end
      checks++;
      if (bus.mem_en !== ((eg_f || eg_d) && inr)
          || (bus.mem_en && (bus.mem_addr !== idx || bus.mem_we !== (eg_d && bus.dbg_we)))) begin
        failures++; $display("FAIL rnd_mem n=%0d got=en%b we%b a%0d exp_inr=%b a%0d", n,
          bus.mem_en, bus.mem_we, bus.mem_addr, inr, idx);
      end
      rd = inr ? ref_mem[idx] : NOP;
      exp_fv = eg_f;                  exp_fd = rd;
      exp_dv = eg_d && !bus.dbg_we;   exp_dd = rd;
      if (eg_d && bus.dbg_we && inr) ref_mem[idx] = bus.dbg_wdata;
      e_mis  = ((eg_f || eg_d) && is_mis) || (e_mis && !bus.err_clr);
      e_rng  = ((eg_f || eg_d) && !inr)   || (e_rng && !bus.err_clr);
      denied = (bus.dbg_req && !eg_d) ? denied + 1 : 0;
      locked = bus.dbg_lock;
      f_pend = bus.fetch_req && !eg_f;
      d_pend = bus.dbg_req && !eg_d;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_seq();
    test_starve();
    test_lock();
    test_range();
    test_misalign();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
